// File: rtl/wino_pkg.sv
// rtl/wino_pkg.sv - shared tile types, constants and FSM states for the Winograd EWMM stage
package wino_pkg;
   localparam int TILE_N = 6;
   localparam logic [7:0] EMPTY_ADDR = 8'hFF;
   localparam int IN_W = 14;
   localparam int K_W = 16;
   localparam int PROD_W = 30;
   localparam int ACC_W_DEF = 34;

   typedef logic [TILE_N-1:0][TILE_N-1:0][IN_W-1:0]      tile14_t;
   typedef logic [TILE_N-1:0][TILE_N-1:0][K_W-1:0]       ktile16_t;
   typedef logic [TILE_N-1:0][TILE_N-1:0][PROD_W-1:0]    prod_tile_t;
   typedef logic [TILE_N-1:0][TILE_N-1:0][ACC_W_DEF-1:0] acc_tile_t;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DRAIN} state_t;
endpackage

// File: rtl/winograd_ewmm_acc_if.sv
// rtl/winograd_ewmm_acc_if.sv - tile input lanes, control and drain output bundle
interface winograd_ewmm_acc_if #(parameter int ACC_W = 34);
   import wino_pkg::*;

   logic                                  start_i;
   logic [7:0]                            block_cnt_i;
   logic [3:0]                            ch_cnt_i;
   logic [3:0]                            chan_i;
   ktile16_t                              kernel_tile_i;
   logic                                  tile_valid_i;
   tile14_t                               tile_1_i;
   tile14_t                               tile_2_i;
   logic [7:0]                            tile_addr_1_i;
   logic [7:0]                            tile_addr_2_i;
   logic                                  busy_o;
   logic                                  acc_valid_o;
   logic [TILE_N-1:0][TILE_N-1:0][ACC_W-1:0] acc_tile_o;
   logic [7:0]                            acc_block_o;
   logic                                  done_o;
   logic                                  err_o;

   modport master (
      output start_i, block_cnt_i, ch_cnt_i, chan_i, kernel_tile_i, tile_valid_i,
             tile_1_i, tile_2_i, tile_addr_1_i, tile_addr_2_i,
      input  busy_o, acc_valid_o, acc_tile_o, acc_block_o, done_o, err_o
   );

   modport slave (
      input  start_i, block_cnt_i, ch_cnt_i, chan_i, kernel_tile_i, tile_valid_i,
             tile_1_i, tile_2_i, tile_addr_1_i, tile_addr_2_i,
      output busy_o, acc_valid_o, acc_tile_o, acc_block_o, done_o, err_o
   );
endinterface

// File: rtl/wino_tile_mul.sv
// rtl/wino_tile_mul.sv - registered 6x6 signed element-wise multiply for one lane
module wino_tile_mul
   import wino_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  tile14_t    tile_i,
   input  ktile16_t   ktile_i,
   output prod_tile_t prod_o
);
   prod_tile_t prod_q, prod_d;

   // Operands are sign-extended to the product width so the truncated result is exact.
   always_comb begin
      prod_d = '0;
      for (int i = 0; i < TILE_N; i++) begin
         for (int j = 0; j < TILE_N; j++) begin
            prod_d[i][j] = PROD_W'($signed(tile_i[i][j])) * PROD_W'($signed(ktile_i[i][j]));
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) prod_q <= '0;
      else       prod_q <= prod_d;
   end

   assign prod_o = prod_q;
endmodule

// File: rtl/winograd_ewmm_acc.sv
// rtl/winograd_ewmm_acc.sv - two-lane multiply-accumulate over input channels, per-block drain
module winograd_ewmm_acc
   import wino_pkg::*;
#(
   parameter int MAX_BLOCKS = 16,
   parameter int ACC_W      = 34
) (
   input logic clk,
   input logic reset,
   winograd_ewmm_acc_if.slave bus
);
   localparam int BLK_W = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
   typedef logic [TILE_N-1:0][TILE_N-1:0][ACC_W-1:0] acc_t;

   state_t           state_q, state_d;
   logic [7:0]       bc_q, bc_d;
   logic [3:0]       ch_q, ch_d;
   logic [12:0]      tile_cnt_q, tile_cnt_d;
   logic [7:0]       drain_idx_q, drain_idx_d;
   logic             err_q, err_d;
   logic [1:0]       s1_en_q, s1_en_d;
   logic [BLK_W-1:0] s1_blk1_q, s1_blk1_d, s1_blk2_q, s1_blk2_d;
   logic             s1_first_q, s1_first_d;
   logic             acc_valid_q, acc_valid_d;
   logic             done_q, done_d;
   logic [7:0]       acc_block_q, acc_block_d;
   acc_t             acc_tile_q, acc_tile_d;
   acc_t             acc_q [MAX_BLOCKS];
   acc_t             acc_d [MAX_BLOCKS];
   prod_tile_t       prod1, prod2;

   logic [11:0] chan_base;
   logic [12:0] off1, off2, total;
   logic        used1, used2, ok1, ok2, take1, take2;

   wino_tile_mul u_mul1 (.clk(clk), .reset(reset), .tile_i(bus.tile_1_i),
                         .ktile_i(bus.kernel_tile_i), .prod_o(prod1));
   wino_tile_mul u_mul2 (.clk(clk), .reset(reset), .tile_i(bus.tile_2_i),
                         .ktile_i(bus.kernel_tile_i), .prod_o(prod2));

   function automatic acc_t acc_update(acc_t cur, prod_tile_t p, logic first);
      acc_t             r;
      logic [ACC_W-1:0] ext;
      r = '0;
      for (int i = 0; i < TILE_N; i++) begin
         for (int j = 0; j < TILE_N; j++) begin
            ext     = ACC_W'($signed(p[i][j]));
            r[i][j] = first ? ext : cur[i][j] + ext;
         end
      end
      return r;
   endfunction

   // A negative offset wraps high in 13 bits, so one unsigned compare rejects both ends.
   always_comb begin
      chan_base = 12'(bc_q) * 12'(bus.chan_i);
      off1      = {5'd0, bus.tile_addr_1_i} - {1'b0, chan_base};
      off2      = {5'd0, bus.tile_addr_2_i} - {1'b0, chan_base};
      used1     = bus.tile_valid_i && (bus.tile_addr_1_i != EMPTY_ADDR);
      used2     = bus.tile_valid_i && (bus.tile_addr_2_i != EMPTY_ADDR);
      ok1       = used1 && (off1 < {5'd0, bc_q}) && (off1 < 13'(MAX_BLOCKS));
      ok2       = used2 && (off2 < {5'd0, bc_q}) && (off2 < 13'(MAX_BLOCKS));
      take1     = (state_q == ST_ACCUM) && ok1;
      take2     = (state_q == ST_ACCUM) && ok2 && !(ok1 && (off1 == off2));
      total     = 13'(bc_q) * (13'(ch_q) + 13'd1);
   end

   // Reads come straight from the flop array, so a write on the previous edge is already visible.
   always_comb begin
      for (int b = 0; b < MAX_BLOCKS; b++) acc_d[b] = acc_q[b];
      if (s1_en_q[0]) acc_d[s1_blk1_q] = acc_update(acc_q[s1_blk1_q], prod1, s1_first_q);
      if (s1_en_q[1]) acc_d[s1_blk2_q] = acc_update(acc_q[s1_blk2_q], prod2, s1_first_q);
   end

   always_comb begin
      state_d     = state_q;
      bc_d        = bc_q;
      ch_d        = ch_q;
      tile_cnt_d  = tile_cnt_q + 13'(take1) + 13'(take2);
      drain_idx_d = drain_idx_q;
      err_d       = err_q | (used1 && !take1) | (used2 && !take2);
      s1_en_d     = {take2, take1};
      s1_blk1_d   = off1[BLK_W-1:0];
      s1_blk2_d   = off2[BLK_W-1:0];
      s1_first_d  = (bus.chan_i == 4'd0);
      acc_valid_d = 1'b0;
      done_d      = 1'b0;
      acc_block_d = '0;
      acc_tile_d  = '0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start_i) begin
               bc_d        = bus.block_cnt_i;
               ch_d        = bus.ch_cnt_i;
               tile_cnt_d  = '0;
               drain_idx_d = '0;
               err_d       = (bus.block_cnt_i == 8'd0);
               if (bus.block_cnt_i != 8'd0) state_d = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if ((tile_cnt_q == total) && (s1_en_q == 2'b00)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (drain_idx_q < bc_q) begin
               acc_valid_d = 1'b1;
               acc_tile_d  = acc_q[drain_idx_q[BLK_W-1:0]];
               acc_block_d = drain_idx_q;
               done_d      = (drain_idx_q == bc_q - 8'd1);
               drain_idx_d = drain_idx_q + 8'd1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bc_q        <= '0;
         ch_q        <= '0;
         tile_cnt_q  <= '0;
         drain_idx_q <= '0;
         err_q       <= 1'b0;
         s1_en_q     <= '0;
         s1_blk1_q   <= '0;
         s1_blk2_q   <= '0;
         s1_first_q  <= 1'b0;
         acc_valid_q <= 1'b0;
         done_q      <= 1'b0;
         acc_block_q <= '0;
         acc_tile_q  <= '0;
      end else begin
         state_q     <= state_d;
         bc_q        <= bc_d;
         ch_q        <= ch_d;
         tile_cnt_q  <= tile_cnt_d;
         drain_idx_q <= drain_idx_d;
         err_q       <= err_d;
         s1_en_q     <= s1_en_d;
         s1_blk1_q   <= s1_blk1_d;
         s1_blk2_q   <= s1_blk2_d;
         s1_first_q  <= s1_first_d;
         acc_valid_q <= acc_valid_d;
         done_q      <= done_d;
         acc_block_q <= acc_block_d;
         acc_tile_q  <= acc_tile_d;
      end
   end

   // Accumulator contents need no reset: the first channel overwrites every block.
   always_ff @(posedge clk) begin
      for (int b = 0; b < MAX_BLOCKS; b++) acc_q[b] <= acc_d[b];
   end

   assign bus.busy_o      = (state_q != ST_IDLE);
   assign bus.acc_valid_o = acc_valid_q;
   assign bus.acc_tile_o  = acc_tile_q;
   assign bus.acc_block_o = acc_block_q;
   assign bus.done_o      = done_q;
   assign bus.err_o       = err_q;
endmodule

// File: doc/winograd_ewmm_acc.md
# winograd_ewmm_acc

Element-wise multiply-accumulate stage directly downstream of the Winograd input transform. It consumes two transformed 6x6 input tiles per cycle and multiplies each by the transformed kernel tile for the current input channel. Products are accumulated per spatial block across all input channels. After the last channel, the block drains one accumulated 6x6 tile per cycle to the output-transform stage.

## Interface
Parameters:
- MAX_BLOCKS, 16, accumulator depth (blocks per channel)
- ACC_W, 34, accumulator element width (signed)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start_i  in  1  one-cycle pulse; latches block_cnt_i and ch_cnt_i; accepted only in IDLE
- block_cnt_i  in  8  blocks per channel (1..MAX_BLOCKS)
- ch_cnt_i  in  4  input channels minus one
- chan_i  in  4  channel id of tiles currently arriving
- kernel_tile_i  in  16x[5:0][5:0]  signed transformed kernel U for chan_i; held stable while that channel streams
- tile_valid_i  in  1  tile lanes valid this cycle
- tile_1_i, tile_2_i  in  14x[5:0][5:0]  signed transformed input tiles
- tile_addr_1_i, tile_addr_2_i  in  8  global tile address = block_cnt*chan + block; 8'hFF marks the lane empty
- busy_o  out  1  high outside IDLE; reset 0
- acc_valid_o  out  1  drain tile valid; reset 0
- acc_tile_o  out  ACC_Wx[5:0][5:0]  accumulated tile; reset all 0
- acc_block_o  out  8  block index of acc_tile_o; reset 0
- done_o  out  1  pulses with the last drained tile; reset 0
- err_o  out  1  sticky protocol error; cleared by start_i or reset; reset 0

## Operation
- States: IDLE -> ACCUM on start_i; ACCUM -> DRAIN when the tile counter reaches block_cnt*(ch_cnt+1) and the pipeline is empty; DRAIN -> IDLE after emitting block_cnt tiles.
- Lane acceptance in ACCUM:
  - A lane is used when tile_valid_i=1 and its address is not 8'hFF.
  - Block index blk = addr - block_cnt*chan_i.
- Stage 1 registers the following:
  - 36 products tile[i][j]*U[i][j] per lane; each product is 30-bit signed.
  - blk per lane.
  - Lane enables.
  - first = (chan_i==0).
- Stage 2 performs read-modify-write of acc[blk]:
  - If first, write the sign-extended product.
  - Otherwise write acc + product, wrapping in two's complement at ACC_W.
- Lanes within one channel never alias. Back-to-back same-block updates (block_cnt=1) must still read the just-written value.
- The tile counter increments by the number of used lanes per cycle.
- DRAIN emits blocks in order 0..block_cnt-1, one per cycle. acc_tile_o is the registered acc[blk]; it is zeros when acc_valid_o=0.
- Errors set err_o and drop the offending lane without updating state:
  - blk >= block_cnt or blk >= MAX_BLOCKS.
  - Both lanes with the same blk (lane 2 dropped).
  - tile_valid_i with a used lane in IDLE or DRAIN.
  - block_cnt_i=0 at start (the block then returns to IDLE immediately, with no drain).
- start_i outside IDLE is ignored.
- reset mid-operation returns to IDLE and zeroes outputs and counters. The accumulator contents are don't-care, because first overwrites them.

## Timing
- Tile sampled at edge N: products registered at N+1; accumulator updated at N+2.
- Last tile sampled at edge N: state becomes DRAIN at N+2. acc_valid_o is high after edges N+3 .. N+2+block_cnt.
- done_o is high together with the final acc_valid_o. busy_o drops on the following edge.
- No backpressure: the downstream stage must accept one tile per cycle during DRAIN.

## Structure
- Shared package wino_pkg:
  - tile typedefs (tile14_t, ktile16_t, acc_tile_t).
  - constants TILE_N=6 and EMPTY_ADDR=8'hFF.
  - state enum.
- Sub-module wino_tile_mul: the 36-element signed multiply for one lane, registered. It is instantiated twice.
- FSM, counters and accumulator array live in the top module.

## Test plan
- block_cnt=4, ch_cnt=0, U all 1, tiles all 2 at addrs 0/1, 2/3 -> four drained tiles, every element 2, acc_block_o 0..3, done_o on block 3.
- block_cnt=3, ch_cnt=1, U=3 then U=-1:
  - Channel 0: tiles of value 5 at addrs 0/1, then 2/FF.
  - Channel 1: tiles of value 5 at addrs 3/4, then 5/FF.
  - Required: drained elements all 10; the FF lane is not counted.
- block_cnt=1, ch_cnt=3, tile value 100, U=200 on consecutive cycles -> single drained tile, every element 80000 (forwarding exercised).
- Extremes: tile=-8192, U=-32768, ch_cnt=15, block_cnt=1 -> element 16*268435456 = 4294967296 exactly; no wrap at ACC_W=34.
- Errors:
  - Duplicate blk on both lanes -> err_o=1; lane 1 accumulated only.
  - Addr 9 with block_cnt=4, chan 0 -> dropped, err_o=1.
  - A following start_i clears err_o.
- Reset asserted mid-DRAIN after two tiles -> outputs 0 next cycle, busy_o=0; a fresh run then produces correct values.
